// File: rtl/sha256_compress_iter.sv
// Iterative SHA-256 compression: 64 rounds over a sliding 16-word schedule,
// ROUNDS_PER_CYCLE rounds unrolled per clock, result returned over valid/ready.
module sha256_compress_iter #(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int WORD_WIDTH       = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] block_in,
    input  logic [255:0] hash_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] hash_out,
    output logic         busy,
    output logic [1:0]   state_dbg
);
    localparam int R = ROUNDS_PER_CYCLE;

    generate
        if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds
            $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
        end
        if (WORD_WIDTH != 32) begin : g_bad_width
            $error("WORD_WIDTH must be 32");
        end
    endgenerate

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; valid never waits on ready, and data holds while valid is unanswered.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t       state_q;
    state_t       state_next;
    logic [255:0] work_q;
    logic [255:0] hsave_q;
    logic [31:0]  w_q [0:15];
    logic [6:0]   rnd_q;
    logic [255:0] work_next;
    logic [31:0]  w_next [0:15];
    logic [255:0] fin_sum;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // One SHA-256 round on the packed {a,b,c,d,e,f,g,h} working state.
    function automatic logic [255:0] round_step(input logic [255:0] s, input logic [31:0] k,
                                                input logic [31:0] wt);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + big_sigma1(e) + ch(e, f, g) + k + wt;
        t2 = big_sigma0(a) + maj(a, b, c);
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    function automatic logic [31:0] k_const(input logic [5:0] idx);
        k_const = 32'h0;
        case (idx)
            6'd0:  k_const = 32'h428a2f98;
            6'd1:  k_const = 32'h71374491;
            6'd2:  k_const = 32'hb5c0fbcf;
            6'd3:  k_const = 32'he9b5dba5;
            6'd4:  k_const = 32'h3956c25b;
            6'd5:  k_const = 32'h59f111f1;
            6'd6:  k_const = 32'h923f82a4;
            6'd7:  k_const = 32'hab1c5ed5;
            6'd8:  k_const = 32'hd807aa98;
            6'd9:  k_const = 32'h12835b01;
            6'd10: k_const = 32'h243185be;
            6'd11: k_const = 32'h550c7dc3;
            6'd12: k_const = 32'h72be5d74;
            6'd13: k_const = 32'h80deb1fe;
            6'd14: k_const = 32'h9bdc06a7;
            6'd15: k_const = 32'hc19bf174;
            6'd16: k_const = 32'he49b69c1;
            6'd17: k_const = 32'hefbe4786;
            6'd18: k_const = 32'h0fc19dc6;
            6'd19: k_const = 32'h240ca1cc;
            6'd20: k_const = 32'h2de92c6f;
            6'd21: k_const = 32'h4a7484aa;
            6'd22: k_const = 32'h5cb0a9dc;
            6'd23: k_const = 32'h76f988da;
            6'd24: k_const = 32'h983e5152;
            6'd25: k_const = 32'ha831c66d;
            6'd26: k_const = 32'hb00327c8;
            6'd27: k_const = 32'hbf597fc7;
            6'd28: k_const = 32'hc6e00bf3;
            6'd29: k_const = 32'hd5a79147;
            6'd30: k_const = 32'h06ca6351;
            6'd31: k_const = 32'h14292967;
            6'd32: k_const = 32'h27b70a85;
            6'd33: k_const = 32'h2e1b2138;
            6'd34: k_const = 32'h4d2c6dfc;
            6'd35: k_const = 32'h53380d13;
            6'd36: k_const = 32'h650a7354;
            6'd37: k_const = 32'h766a0abb;
            6'd38: k_const = 32'h81c2c92e;
            6'd39: k_const = 32'h92722c85;
            6'd40: k_const = 32'ha2bfe8a1;
            6'd41: k_const = 32'ha81a664b;
            6'd42: k_const = 32'hc24b8b70;
            6'd43: k_const = 32'hc76c51a3;
            6'd44: k_const = 32'hd192e819;
            6'd45: k_const = 32'hd6990624;
            6'd46: k_const = 32'hf40e3585;
            6'd47: k_const = 32'h106aa070;
            6'd48: k_const = 32'h19a4c116;
            6'd49: k_const = 32'h1e376c08;
            6'd50: k_const = 32'h2748774c;
            6'd51: k_const = 32'h34b0bcb5;
            6'd52: k_const = 32'h391c0cb3;
            6'd53: k_const = 32'h4ed8aa4a;
            6'd54: k_const = 32'h5b9cca4f;
            6'd55: k_const = 32'h682e6ff3;
            6'd56: k_const = 32'h748f82ee;
            6'd57: k_const = 32'h78a5636f;
            6'd58: k_const = 32'h84c87814;
            6'd59: k_const = 32'h8cc70208;
            6'd60: k_const = 32'h90befffa;
            6'd61: k_const = 32'ha4506ceb;
            6'd62: k_const = 32'hbef9a3f7;
            6'd63: k_const = 32'hc67178f2;
            default: k_const = 32'h0;
        endcase
    endfunction

    // R chained rounds plus R new schedule words; later words in the same cycle
    // feed from earlier ones through ext[16..].
    always_comb begin : datapath
        logic [255:0] s;
        logic [31:0]  ext [0:15+R];
        s = work_q;
        for (int j = 0; j < R; j++) begin
            s = round_step(s, k_const(6'(rnd_q[5:0] + 6'(j))), w_q[j]);
        end
        work_next = s;
        for (int i = 0; i < 16; i++) begin
            ext[i] = w_q[i];
        end
        for (int j = 0; j < R; j++) begin
            ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
        end
        for (int i = 0; i < 16; i++) begin
            w_next[i] = ext[i+R];
        end
        fin_sum = '0;
        for (int i = 0; i < 8; i++) begin
            fin_sum[255-32*i -: 32] = hsave_q[255-32*i -: 32] + work_q[255-32*i -: 32];
        end
    end

    always_comb begin : fsm_next
        state_next = state_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (rnd_q == 7'(64 - R)) state_next = FIN;
            end
            FIN: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            work_q   <= '0;
            hsave_q  <= '0;
            rnd_q    <= '0;
            hash_out <= '0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else begin
            state_q <= state_next;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q  <= hash_in;
                        hsave_q <= hash_in;
                        rnd_q   <= '0;
                        for (int i = 0; i < 16; i++) w_q[i] <= block_in[511-32*i -: 32];
                    end
                end
                RUN: begin
                    work_q <= work_next;
                    rnd_q  <= rnd_q + 7'(R);
                    for (int i = 0; i < 16; i++) w_q[i] <= w_next[i];
                end
                FIN:     hash_out <= fin_sum;
                default: ;
            endcase
        end
    end

    assign state_dbg = state_q;

endmodule

// File: doc/sha256_compress_iter.md
# sha256_compress_iter

Iterative SHA-256 compression engine: it accepts one 512-bit message block and a 256-bit chaining value, then runs all 64 rounds internally. The block owns the K-constant ROM and the 16-word sliding message schedule, and returns the feed-forward-added 256-bit result over a valid/ready handshake. Each clock cycle unrolls ROUNDS_PER_CYCLE copies of the single-round datapath, so one parameter trades area against latency. It sits between the message padder and the digest/chaining register in the hashing core.

## Interface
- ROUNDS_PER_CYCLE, 1, rounds evaluated per clock. Legal values: 1, 2, 4, 8. Any other value is an elaboration error.
- WORD_WIDTH, 32, SHA-256 word width. Fixed at 32; any other value is an elaboration error.
- clk  input  1  sole clock; all state updates on the rising edge
- rst  input  1  reset, synchronous and active-high
- in_valid  input  1  block_in/hash_in are valid
- in_ready  output  1  engine can accept a block
- block_in  input  512  message words W0..W15; W0 = [511:480]
- hash_in  input  256  chaining value H0..H7; H0 (a) = [255:224]
- out_valid  output  1  hash_out is valid
- out_ready  input  1  consumer accepts hash_out
- hash_out  output  256  updated chaining value, same packing as hash_in
- busy  output  1  high in RUN and FIN

## Operation
- States: IDLE, RUN, FIN, DONE.
- IDLE
  - in_ready=1.
  - On in_valid&&in_ready: latch hash_in into both the a..h working registers and the H save register, latch block_in into the schedule window w[0..15], set rnd=0, go to RUN.
- RUN, each edge:
  - Apply ROUNDS_PER_CYCLE chained rounds j=0..R-1, using round index rnd+j, Wt = w[j] and K[rnd+j]. Each round computes:
    - T1 = h + Σ1(e) + Ch(e,f,g) + K + W
    - T2 = Σ0(a) + Maj(a,b,c)
    - a' = T1 + T2, e' = d + T1; b,c,d and f,g,h shift.
  - Rotations: Σ0 = rotr 2/13/22, Σ1 = rotr 6/11/25.
  - Schedule: shift the window by R words and append R new words. Each new word is σ1(w[t-2]) + w[t-7] + σ0(w[t-15]) + w[t-16], where σ0 = rotr7^rotr18^shr3 and σ1 = rotr17^rotr19^shr10. New words generated in the same cycle chain combinationally onto earlier new words from that cycle.
  - rnd += R. When the step that reaches rnd==64 completes, go to FIN.
  - Schedule words for t≥64 are don't-care.
- FIN (one cycle): hash_out[i] = H[i] + working[i] for i=0..7, all modulo 2^32 per word with no carry between words. Set out_valid=1 and go to DONE.
- DONE
  - Hold hash_out and out_valid until out_ready.
  - On out_valid&&out_ready, clear out_valid and go to IDLE.
- Inputs are ignored outside IDLE; in_ready=0 in RUN, FIN and DONE.
- All additions are 32-bit wrap-around.
- K ROM holds the 64 standard SHA-256 constants, indexed by round number.

## Timing
- Reset, whether idle or mid-operation:
  - state=IDLE, in_ready=1 (first cycle after the reset edge), out_valid=0, busy=0, hash_out=0, rnd=0.
  - Working, H and schedule registers are cleared to 0.
  - An in-flight block is discarded; no out_valid is produced for it.
- Let N = 64/ROUNDS_PER_CYCLE.
- Accept on edge E0. RUN occupies the cycles after edges E0..E(N-1); edges E1..EN each perform R rounds. FIN is evaluated on edge E(N+1).
- out_valid is first high after edge E(N+1): a latency of N+1 edges.
- Minimum initiation interval is N+3 cycles: accept, N RUN edges, FIN, and one DONE handshake cycle with out_ready=1 held.
- out_ready held high at FIN gives a single-cycle out_valid pulse. out_ready low stalls indefinitely with hash_out stable.
- in_valid may be held high across a busy period; the next accept occurs in the first IDLE cycle.
- busy=1 from the cycle after accept through the FIN cycle; busy=0 in IDLE and DONE.

## Test plan
- **"abc":** block_in = 0x61626380, thirteen 0 words, then 0x00000000, 0x00000018; hash_in = standard IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19). Required: hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, out_valid exactly N+1 edges after accept. Run for R = 1, 2, 4, 8.
- **Empty message:** block_in = 0x80000000 followed by 15 zero words, IV as above. Required: hash_out = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- **Backpressure:** out_ready=0 for 20 cycles after out_valid. Required: hash_out stable and in_ready=0 throughout. Raise out_ready: one handshake, then in_ready=1 on the next cycle.
- **Reset mid-run:** assert rst at rnd=32 (R=1). Required: the next cycle shows in_ready=1, out_valid=0, hash_out=0. A subsequent "abc" run gives the correct digest.
- **Continuous in_valid:** in_valid held high with out_ready=1 over 3 blocks, feeding each digest back as the next hash_in. Required: accepts spaced exactly N+3 cycles apart, and results match a reference model.
- **Random:** 1000 random blocks and hash_in values against a software compression model, with random out_ready stalls. Required: zero mismatches.
